// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the PC, imem req/gnt/rvalid fetch, valid/ready decode hand-off.
// Optional IF_PERF_CNT_EN adds a saturating stall_cnt output.
module if_fetch_unit #(
    parameter logic [31:2] RESET_PC = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:2] pc,
    input  logic [31:2] npc,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:2] inst_pc,
    input  logic        inst_ready,
    input  logic        flush,
    input  logic [31:2] flush_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:2] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:2] inst_pc_q, inst_pc_d;

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign imem_req   = state_q == S_REQ;
    assign inst_valid = state_q == S_HOLD;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (flush) begin
            pc_d = flush_pc;
            case (state_q)
                S_REQ:   state_d = imem_gnt ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   state_d = imem_gnt ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        pc_d    = npc;
                        state_d = S_REQ;
                    end
                end
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    assign stall = (state_q == S_REQ && !imem_gnt) || (state_q == S_WAIT && !imem_rvalid) ||
                   (state_q == S_HOLD && !inst_ready) || state_q == S_DRAIN;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = (stall && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:2] pc, npc, imem_addr, inst_pc, flush_pc;
    logic        imem_req, imem_gnt, imem_rvalid, inst_valid, inst_ready, flush;
    logic [31:0] imem_rdata, inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif
    int total = 0;
    int bad = 0;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .npc(npc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .flush(flush), .flush_pc(flush_pc)
`ifdef IF_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; npc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; flush = 1'b0; flush_pc = '0;
        cyc();
        cyc();
        check("rst_pc", 32'(pc), 32'h0C00);
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", 32'(inst_pc), 32'h0C00);
        rst = 1'b0;
        check("idle_req", 32'(imem_req), 0);
        cyc();
        check("req_on", 32'(imem_req), 1);
        check("req_addr", 32'(imem_addr), 32'h0C00);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("gstall_req", 32'(imem_req), 1);
            check("gstall_addr", 32'(imem_addr), 32'h0C00);
        end
        imem_gnt = 1'b1;
        cyc();
        check("wait_req", 32'(imem_req), 0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2408_0005;
        cyc();
        imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        check("hold_valid", 32'(inst_valid), 1);
        check("hold_inst", inst, 32'h2408_0005);
        check("hold_inst_pc", 32'(inst_pc), 32'h0C00);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_valid", 32'(inst_valid), 1);
            check("bp_inst", inst, 32'h2408_0005);
            check("bp_inst_pc", 32'(inst_pc), 32'h0C00);
            check("bp_req", 32'(imem_req), 0);
        end
`ifdef IF_PERF_CNT_EN
        check("cnt_bp", stall_cnt, 8);
`endif
        inst_ready = 1'b1; npc = 30'h0C01;
        cyc();
        inst_ready = 1'b0;
        check("adv_pc", 32'(pc), 32'h0C01);
        check("adv_req", 32'(imem_req), 1);
        check("adv_addr", 32'(imem_addr), 32'h0C01);
        check("adv_valid", 32'(inst_valid), 0);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; flush = 1'b1; flush_pc = 30'h0D00;
        cyc();
        flush = 1'b0;
        check("fw_pc", 32'(pc), 32'h0D00);
        check("fw_req", 32'(imem_req), 0);
        cyc();
        check("drain_valid", 32'(inst_valid), 0);
        check("drain_req", 32'(imem_req), 0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0;
        check("orph_valid", 32'(inst_valid), 0);
        check("orph_inst", inst, 32'h2408_0005);
        check("orph_req", 32'(imem_req), 1);
        check("orph_addr", 32'(imem_addr), 32'h0D00);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        cyc();
        imem_rvalid = 1'b0;
        check("h2_inst", inst, 32'h1111_2222);
        check("h2_inst_pc", 32'(inst_pc), 32'h0D00);
        inst_ready = 1'b1; flush = 1'b1; npc = 30'h0C05; flush_pc = 30'h0E00;
        cyc();
        inst_ready = 1'b0; flush = 1'b0;
        check("col_pc", 32'(pc), 32'h0E00);
        check("col_valid", 32'(inst_valid), 0);
        check("col_req", 32'(imem_req), 1);
`ifdef IF_PERF_CNT_EN
        check("cnt_col", stall_cnt, 11);
`endif
        flush = 1'b1; flush_pc = 30'h0F00;
        cyc();
        flush = 1'b0;
        check("freq_req", 32'(imem_req), 1);
        check("freq_addr", 32'(imem_addr), 32'h0F00);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_ABCD;
        cyc();
        imem_rvalid = 1'b0;
        check("mrst_inst", inst, 0);
        check("mrst_valid", 32'(inst_valid), 0);
        check("mrst_req", 32'(imem_req), 1);
        check("mrst_pc", 32'(pc), 32'h0C00);
`ifdef IF_PERF_CNT_EN
        check("cnt_mrst", stall_cnt, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that owns the architectural PC register (word address [31:2]).
- Drives the current PC to the next-PC calculator and takes back its result as the next PC.
- Fetches from instruction memory over a request/grant + response handshake.
- Presents one instruction at a time to decode over a valid/ready handshake; supports flush/redirect with discard of in-flight responses.

Parameters:
- RESET_PC, 30'h0000_0C00, word address loaded on reset (byte address 0x0000_3000)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc  output  [31:2]  current PC register, to next-PC calculator
- npc  input  [31:2]  next PC from next-PC calculator, sampled on decode handshake
- imem_req  output  1  fetch request valid
- imem_addr  output  [31:2]  fetch word address, equals pc
- imem_gnt  input  1  memory accepts request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- inst_valid  output  1  instruction available to decode
- inst  output  32  held instruction word
- inst_pc  output  [31:2]  PC of held instruction
- inst_ready  input  1  decode accepts instruction
- flush  input  1  redirect request
- flush_pc  input  [31:2]  redirect target

Behaviour:
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN.
- Reset (rst=1 at edge): state<=S_IDLE, pc<=RESET_PC, inst<=0, inst_pc<=RESET_PC, inst_valid<=0. Overrides flush and all handshakes. Reset mid-transaction: a late imem_rvalid after reset is ignored while in S_IDLE.
- Output decode: imem_req=1 only in S_REQ; imem_addr=pc always; inst_valid=1 only in S_HOLD.
- S_IDLE: unconditionally -> S_REQ next cycle.
- S_REQ: when imem_gnt=1 -> S_WAIT; otherwise stay, with imem_req held and imem_addr stable.
- S_WAIT:
  - imem_rvalid is sampled only in S_WAIT/S_DRAIN. A response in the same cycle as the grant is not supported; memory returns data at least 1 cycle after gnt.
  - When imem_rvalid=1: inst<=imem_rdata, inst_pc<=pc, -> S_HOLD.
- S_HOLD:
  - inst/inst_pc are stable while inst_valid=1 and inst_ready=0.
  - When inst_ready=1: pc<=npc, -> S_REQ.
- Throughput: minimum 3 cycles per instruction (REQ+gnt, WAIT+rvalid, HOLD+ready).
- Flush (evaluated every non-reset cycle; has priority over gnt, rvalid and inst_ready):
  - pc<=flush_pc. The npc value is ignored that cycle.
  - S_REQ with gnt=0 -> S_REQ (the new address is presented next cycle).
  - S_REQ with gnt=1 -> S_DRAIN.
  - S_WAIT with rvalid=0 -> S_DRAIN.
  - S_WAIT with rvalid=1 -> S_REQ (data discarded).
  - S_HOLD -> S_REQ (instruction dropped, inst_valid=0 next cycle).
  - S_IDLE -> S_REQ.
  - S_DRAIN -> S_DRAIN.
- S_DRAIN: waits for the orphaned response. On imem_rvalid=1 -> S_REQ, data discarded, inst unchanged.
- Arithmetic: none inside the block; the PC is always word-aligned by construction. Wrap-around of pc is the calculator's concern; values are taken verbatim.
- Only one outstanding memory request at any time.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cnt [31:0].
  - Reset 0.
  - Increments by 1 each cycle in S_REQ with imem_gnt=0, in S_WAIT with imem_rvalid=0, in S_HOLD with inst_ready=0, or in S_DRAIN.
  - Saturates at 32'hFFFF_FFFF; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release: rst high 2 cycles then low -> pc=30'h0C00, imem_req=0 for 1 cycle after release (S_IDLE), then imem_req=1 with imem_addr=30'h0C00.
- Zero-wait fetch: gnt in S_REQ, rvalid with rdata=32'h2408_0005 next cycle, inst_ready=1, npc=30'h0C01 -> inst_valid=1 with inst=32'h2408_0005, inst_pc=30'h0C00; then pc=30'h0C01 and a new request issued.
- Backpressure: hold inst_ready=0 for 5 cycles in S_HOLD -> inst/inst_pc unchanged, no new imem_req; with IF_PERF_CNT_EN, stall_cnt advances by 5.
- Grant stall: imem_gnt=0 for 3 cycles -> imem_req stays 1 and imem_addr stays 30'h0C00 throughout.
- Flush in S_WAIT: flush=1, flush_pc=30'h0D00 before rvalid; orphan rvalid arrives 2 cycles later -> data discarded, inst_valid stays 0, next request addresses 30'h0D00.
- Flush vs ready collision: in S_HOLD, flush=1 and inst_ready=1 same cycle with npc=30'h0C05, flush_pc=30'h0E00 -> pc=30'h0E00, inst_valid=0 next cycle.
